// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: memory-port FSM states
// and instruction field positions.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mp_state_e;

   localparam int unsigned OP_HI    = 31;
   localparam int unsigned OP_LO    = 26;
   localparam int unsigned FUNCT_HI = 5;
   localparam int unsigned FUNCT_LO = 0;

endpackage

// File: rtl/mem_timer.sv
// Saturating wait counter: cleared by i_load, counts while i_en, flags o_expired
// once TIMEOUT enabled cycles have elapsed since the load.
module mem_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_expired
);

   localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_count;
   logic          r_expired;
   logic [CW-1:0] w_inc;

   assign w_inc     = r_count + CW'(1);
   assign o_expired = r_expired;

   // Counting stops at TIMEOUT, so the counter never wraps back to zero.
   always_ff @(posedge clk) begin
      if (rst || i_load) begin
         r_count   <= '0;
         r_expired <= (TIMEOUT == 0);
      end else if (i_en && !r_expired) begin
         r_count   <= w_inc;
         r_expired <= (w_inc == CW'(TIMEOUT));
      end
   end

endmodule

// File: rtl/mem_port.sv
// Memory-port and IR/MDR stage: converts the controller's access strobe into a
// req/ack memory transaction, stalls the controller, and captures read data.
module mem_port
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             access,
   input  logic             iord,
   input  logic             memwrite,
   input  logic             irwrite,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] aluout,
   input  logic [WIDTH-1:0] wdata,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [WIDTH-1:0] instr,
   output logic [5:0]       op,
   output logic [5:0]       funct,
   output logic [WIDTH-1:0] mdr,
   output logic             stall,
   output logic             done,
   output logic             err
);

   mp_state_e        r_state, w_next_state;
   logic             r_req, w_next_req;
   logic             r_we, w_next_we;
   logic [WIDTH-1:0] r_addr, w_next_addr;
   logic [WIDTH-1:0] r_wdata, w_next_wdata;
   logic             r_tgt_ir, w_next_tgt_ir;
   logic [WIDTH-1:0] r_instr, w_next_instr;
   logic [WIDTH-1:0] r_mdr, w_next_mdr;
   logic             r_done, w_next_done;
   logic             r_err, w_next_err;

   logic [WIDTH-1:0] w_addr;
   logic             w_aligned;
   logic             w_start;
   logic             w_expired;

   assign w_addr    = iord ? aluout : pc;
   assign w_aligned = (w_addr[1:0] == 2'b00);
   assign w_start   = (r_state == ST_IDLE) && access && w_aligned;

   mem_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_start),
      .i_en      (r_state == ST_BUSY),
      .o_expired (w_expired)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_tgt_ir <= 1'b0;
         r_instr  <= '0;
         r_mdr    <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_req    <= w_next_req;
         r_we     <= w_next_we;
         r_addr   <= w_next_addr;
         r_wdata  <= w_next_wdata;
         r_tgt_ir <= w_next_tgt_ir;
         r_instr  <= w_next_instr;
         r_mdr    <= w_next_mdr;
         r_done   <= w_next_done;
         r_err    <= w_next_err;
      end
   end

   // Next-state and next-output logic; an ack beats a simultaneous timeout.
   always_comb begin
      w_next_state  = r_state;
      w_next_req    = r_req;
      w_next_we     = r_we;
      w_next_addr   = r_addr;
      w_next_wdata  = r_wdata;
      w_next_tgt_ir = r_tgt_ir;
      w_next_instr  = r_instr;
      w_next_mdr    = r_mdr;
      w_next_done   = 1'b0;
      w_next_err    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (access) begin
               if (w_aligned) begin
                  w_next_state  = ST_BUSY;
                  w_next_req    = 1'b1;
                  w_next_addr   = w_addr;
                  w_next_we     = memwrite;
                  w_next_wdata  = wdata;
                  w_next_tgt_ir = irwrite && !memwrite;
               end else begin
                  w_next_state = ST_DONE;
                  w_next_done  = 1'b1;
                  w_next_err   = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               w_next_state = ST_DONE;
               w_next_req   = 1'b0;
               w_next_we    = 1'b0;
               w_next_done  = 1'b1;
               if (!r_we) begin
                  if (r_tgt_ir) w_next_instr = mem_rdata;
                  else          w_next_mdr   = mem_rdata;
               end
            end else if (w_expired) begin
               w_next_state = ST_DONE;
               w_next_req   = 1'b0;
               w_next_we    = 1'b0;
               w_next_done  = 1'b1;
               w_next_err   = 1'b1;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_req   = 1'b0;
            w_next_we    = 1'b0;
         end
      endcase
   end

   assign mem_req   = r_req;
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign instr     = r_instr;
   assign mdr       = r_mdr;
   assign op        = r_instr[OP_HI:OP_LO];
   assign funct     = r_instr[FUNCT_HI:FUNCT_LO];
   assign done      = r_done;
   assign err       = r_err;

   // Combinational so the controller already holds on the request cycle.
   assign stall = ((r_state == ST_IDLE) && access) || (r_state == ST_BUSY);

endmodule

// File: doc/mem_port.md
# mem_port

Memory-port and instruction/data register stage for the multicycle MIPS core. It sits between the main controller FSM and a variable-latency unified memory. It turns the controller's single-cycle access strobe plus `iord`/`memwrite`/`irwrite` into a req/ack memory transaction and holds the controller with `stall` until the transfer finishes. It captures read data into the instruction register (IR) or the memory data register (MDR), and supplies `op`/`funct` to the controller and the ALU decoder.

## Interface
- `WIDTH`, default 32: data and address width.
- `TIMEOUT`, default 255: maximum BUSY cycles waiting for `mem_ack` before the access is aborted.

- `clk`  in  1  Clock; all state updates on the rising edge.
- `rst`  in  1  Reset; synchronous, active-high.
- `access`  in  1  Controller requests a memory access this cycle.
- `iord`  in  1  Address select: 0 selects `pc`, 1 selects `aluout`.
- `memwrite`  in  1  1 = write, 0 = read.
- `irwrite`  in  1  On a read, 1 loads IR and 0 loads MDR.
- `pc`  in  WIDTH  Instruction address.
- `aluout`  in  WIDTH  Data address.
- `wdata`  in  WIDTH  Store data (register B).
- `mem_req`  out  1  Memory request.
- `mem_we`  out  1  Memory write enable.
- `mem_addr`  out  WIDTH  Memory address.
- `mem_wdata`  out  WIDTH  Memory write data.
- `mem_ack`  in  1  Memory completion, sampled at the clock edge.
- `mem_rdata`  in  WIDTH  Read data; valid when `mem_ack`=1.
- `instr`  out  WIDTH  IR contents.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `mdr`  out  WIDTH  MDR contents.
- `stall`  out  1  Controller must hold its current state.
- `done`  out  1  One-cycle pulse: the access has finished.
- `err`  out  1  Qualifies `done`: the access was misaligned or timed out.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, `access`=1, `addr[1:0]`=0:
  - Latch the address (`iord ? aluout : pc`), `mem_we`=`memwrite`, `mem_wdata`=`wdata`, and the read target (IR if `irwrite`, else MDR).
  - Clear the timeout counter and go to BUSY.
- IDLE, `access`=1, address misaligned: go to DONE with `err`=1. No `mem_req` is issued and IR/MDR are unchanged.
- BUSY:
  - `mem_req`=1, with `mem_addr`, `mem_we` and `mem_wdata` held stable from the latched values.
  - On the edge where `mem_ack`=1: a read loads `mem_rdata` into the latched target; a write loads nothing. Go to DONE with `err`=0.
  - If the counter reaches TIMEOUT with no ack: go to DONE with `err`=1 and leave IR/MDR unchanged.
- DONE: `done`=1, `stall`=0. Go to IDLE unconditionally. `access` is ignored in DONE.
- `stall` = (IDLE & `access`) | BUSY. It is combinational so the controller holds on the request cycle itself.
- `irwrite` is ignored when `memwrite`=1.
- Inputs sampled during BUSY have no effect.

## Timing
- Reset values:
  - FSM in IDLE.
  - `mem_req`, `mem_we`, `done`, `err`, `stall` (with `access`=0) are 0.
  - `mem_addr`, `mem_wdata`, `instr`, `mdr` are 0, so `op` and `funct` are 0.
- Minimum latency: `access` at cycle 0, `mem_req` at cycle 1, ack at cycle 1, `done` at cycle 2. `stall` is high in cycles 0–1.
- `instr` and `mdr` are visible in the same cycle `done` is high.
- `mem_req` deasserts in the cycle after the ack edge, so there are no back-to-back requests without an IDLE.
- Timeout: `done`/`err` appear TIMEOUT+1 cycles after BUSY entry. An ack arriving on the TIMEOUT edge takes priority over the timeout.
- `rst` mid-transaction: at the reset edge the FSM goes to IDLE, `mem_req` drops the next cycle and IR/MDR clear. A late `mem_ack` arriving in IDLE is ignored.
- The timeout counter is wide enough for TIMEOUT and saturates, so it never wraps.

## Structure
- Shared package `mips_pkg`:
  - FSM state enum.
  - Opcode field positions (`OP_HI`=31, `OP_LO`=26, `FUNCT_HI`=5, `FUNCT_LO`=0).
- The address mux, IR/MDR registers and FSM stay in `mem_port`.
- One natural sub-module is `mem_timer`: a load/enable/saturating counter with a `expired` output.

## Test plan
- Fetch, zero-wait: `access`=1, `iord`=0, `irwrite`=1, `pc`=0x40, ack in the first BUSY cycle with `mem_rdata`=0x20080005 -> `mem_addr`=0x40, `done` at cycle 2, `instr`=0x20080005, `op`=0x08, `mdr` unchanged.
- Load with 3 wait states: `iord`=1, `aluout`=0x104, ack on the 4th BUSY cycle with 0xDEADBEEF -> `stall` high for 5 cycles, then `mdr`=0xDEADBEEF and `instr` unchanged.
- Store: `memwrite`=1, `irwrite`=1, `aluout`=0x200, `wdata`=0x1234 -> `mem_we`=1 and `mem_wdata`=0x1234 during BUSY; IR and MDR unchanged; `err`=0.
- Misaligned access: `aluout`=0x203 -> `mem_req` never asserts; `done`=1 and `err`=1 in the next cycle.
- Timeout: TIMEOUT=4, no ack -> `done` and `err` after 5 BUSY cycles; `mem_req` low afterwards; a later stray ack is ignored.
- Reset in BUSY, followed by a fresh fetch -> all outputs return to 0 and the new fetch completes normally.
